// File: rtl/packet_mem_reader.sv
// Packet memory read responder: big-endian byte/halfword/word extraction from a 32-bit BRAM.
// Define PACKET_MEM_UNALIGNED_EN to complete word-spanning reads with a second BRAM access.
module packet_mem_reader #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            transfer_sz_i,
    output logic                  bram_rd_en_o,
    output logic [ADDR_WIDTH-3:0] bram_addr_o,
    input  logic [31:0]           bram_rdata_i,
    output logic [31:0]           resdata_o,
    output logic                  resdata_vld_o,
    output logic                  busy_o
);
    localparam int unsigned WordAw = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StWait1, StWait2} state_e;

    state_e      state_q;
    logic [1:0]  off_q;
    logic [2:0]  nbytes_q;
    logic [31:0] resdata_q;
    logic        resdata_vld_q;

`ifdef PACKET_MEM_UNALIGNED_EN
    localparam logic [WordAw-1:0] WordOne = {{(WordAw-1){1'b0}}, 1'b1};

    logic              spans_q;
    logic [WordAw-1:0] next_word_q;
    logic [31:0]       held_q;
    logic              req_spans;
`endif

    logic [2:0] req_nbytes;

    always_comb begin
        unique case (transfer_sz_i)
            2'b01:   req_nbytes = 3'd2;
            2'b10:   req_nbytes = 3'd1;
            default: req_nbytes = 3'd4;
        endcase
    end

`ifdef PACKET_MEM_UNALIGNED_EN
    assign req_spans = ({2'b00, addr_i[1:0]} + {1'b0, req_nbytes}) > 4'd4;
`endif

    // Shift the wanted bytes to the top of the pair, then right-align the n bytes taken.
    // Bytes past the end of the pair come in as zero, which left-aligns truncated reads.
    function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                            input logic [2:0] n);
        logic [63:0] sh;
        sh = pair << {off, 3'b000};
        return sh[63:32] >> (6'd32 - {n, 3'b000});
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            off_q         <= 2'b00;
            nbytes_q      <= 3'd0;
            resdata_q     <= 32'h0;
            resdata_vld_q <= 1'b0;
`ifdef PACKET_MEM_UNALIGNED_EN
            spans_q       <= 1'b0;
            next_word_q   <= '0;
            held_q        <= 32'h0;
`endif
        end else begin
            resdata_vld_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rd_en_i) begin
                        off_q    <= addr_i[1:0];
                        nbytes_q <= req_nbytes;
`ifdef PACKET_MEM_UNALIGNED_EN
                        spans_q     <= req_spans;
                        next_word_q <= addr_i[ADDR_WIDTH-1:2] + WordOne;
`endif
                        state_q  <= StWait1;
                    end
                end
                StWait1: begin
`ifdef PACKET_MEM_UNALIGNED_EN
                    if (spans_q) begin
                        held_q  <= bram_rdata_i;
                        state_q <= StWait2;
                    end else
`endif
                    begin
                        resdata_q     <= extract({bram_rdata_i, 32'h0}, off_q, nbytes_q);
                        resdata_vld_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
`ifdef PACKET_MEM_UNALIGNED_EN
                StWait2: begin
                    resdata_q     <= extract({held_q, bram_rdata_i}, off_q, nbytes_q);
                    resdata_vld_q <= 1'b1;
                    state_q       <= StIdle;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    // First read goes out straight from the request; the second comes from latched state.
    always_comb begin
        bram_rd_en_o = 1'b0;
        bram_addr_o  = '0;
        if (rst_ni) begin
            if (state_q == StIdle && rd_en_i) begin
                bram_rd_en_o = 1'b1;
                bram_addr_o  = addr_i[ADDR_WIDTH-1:2];
            end
`ifdef PACKET_MEM_UNALIGNED_EN
            else if (state_q == StWait1 && spans_q) begin
                bram_rd_en_o = 1'b1;
                bram_addr_o  = next_word_q;
            end
`endif
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign resdata_o     = resdata_q;
    assign resdata_vld_o = resdata_vld_q;

endmodule

// File: tb/tb_packet_mem_reader.sv
// Self-checking bench for packet_mem_reader against a byte-array reference model.
// Expectations follow PACKET_MEM_UNALIGNED_EN the same way the design does.
module tb_packet_mem_reader;
    localparam int AW    = 12;
    localparam int WORDS = 1 << (AW - 2);

`ifdef PACKET_MEM_UNALIGNED_EN
    localparam bit Unal = 1'b1;
`else
    localparam bit Unal = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [1:0]    sz;
    logic          bram_rd_en;
    logic [AW-3:0] bram_addr;
    logic [31:0]   bram_rdata;
    logic [31:0]   resdata;
    logic          resdata_vld;
    logic          busy;

    logic [31:0] mem [0:WORDS-1];
    int tests_run = 0;
    int fails = 0;

    packet_mem_reader #(.ADDR_WIDTH(AW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rd_en_i       (rd_en),
        .addr_i        (addr),
        .transfer_sz_i (sz),
        .bram_rd_en_o  (bram_rd_en),
        .bram_addr_o   (bram_addr),
        .bram_rdata_i  (bram_rdata),
        .resdata_o     (resdata),
        .resdata_vld_o (resdata_vld),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bram_rd_en) bram_rdata <= mem[bram_addr];
    end

    function automatic logic [7:0] mem_byte(input int ba);
        logic [31:0] wd;
        wd = mem[ba / 4];
        return wd[8 * (3 - (ba % 4)) +: 8];
    endfunction

    // Reference: walk the n requested bytes in address order, most significant first.
    function automatic logic [31:0] model(input int a, input logic [1:0] s);
        int n;
        int o;
        logic [31:0] r;
        n = (s == 2'b01) ? 2 : (s == 2'b10) ? 1 : 4;
        o = a % 4;
        r = 32'h0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            if (Unal || (o + i < 4)) b = mem_byte((a + i) % (1 << AW));
            else b = 8'h00;
            r = (r << 8) | {24'h0, b};
        end
        return r;
    endfunction

    function automatic bit spans(input int a, input logic [1:0] s);
        int n;
        n = (s == 2'b01) ? 2 : (s == 2'b10) ? 1 : 4;
        return (a % 4) + n > 4;
    endfunction

    // Issue one request and record what the DUT does over the following six cycles.
    task automatic run_req(input int a, input logic [1:0] s, input bit poke,
                           output logic [31:0] res, output int vld_cyc, output int vld_cnt,
                           output logic [7:0] busy_mask, output logic en0,
                           output logic [AW-3:0] addr0, output logic en1,
                           output logic [AW-3:0] addr1);
        res = 32'hx; vld_cyc = -1; vld_cnt = 0; busy_mask = 8'h0;
        @(negedge clk);
        rd_en = 1'b1; addr = AW'(a); sz = s;
        #1;
        en0 = bram_rd_en; addr0 = bram_addr;
        busy_mask[0] = busy;
        en1 = 1'b0; addr1 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1 && poke) begin
                rd_en = 1'b1; addr = AW'($urandom_range(0, (1 << AW) - 1)); sz = 2'b10;
            end else begin
                rd_en = 1'b0;
            end
            #1;
            busy_mask[k] = busy;
            if (k == 1) begin en1 = bram_rd_en; addr1 = bram_addr; end
            if (resdata_vld) begin
                vld_cnt++; vld_cyc = k; res = resdata;
            end
        end
        rd_en = 1'b0;
    endtask

    logic [31:0]   r_res;
    int            r_cyc, r_cnt;
    logic [7:0]    r_busy;
    logic          r_en0, r_en1;
    logic [AW-3:0] r_a0, r_a1;

    task automatic test_reset();
        rst_n = 1'b0; rd_en = 1'b1; addr = '0; sz = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || resdata_vld !== 1'b0) begin
            fails++; $display("FAIL reset_flags busy=%b vld=%b want 0 0", busy, resdata_vld);
        end
        tests_run++;
        if (resdata !== 32'h0) begin
            fails++; $display("FAIL reset_resdata got=%h want 00000000", resdata);
        end
        tests_run++;
        if (bram_rd_en !== 1'b0 || bram_addr !== '0) begin
            fails++; $display("FAIL reset_bram en=%b addr=%h want 0 0", bram_rd_en, bram_addr);
        end
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        run_req(0, 2'b00, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        tests_run++;
        if (r_res !== 32'h11223344 || r_cyc != 2 || r_cnt != 1) begin
            fails++;
            $display("FAIL w_addr0 got=%h cyc=%0d cnt=%0d want 11223344 2 1", r_res, r_cyc, r_cnt);
        end
        tests_run++;
        if (r_busy !== 8'b0000_0010 || r_en0 !== 1'b1 || r_a0 !== '0) begin
            fails++;
            $display("FAIL w_addr0_timing busy=%b en=%b a=%h want 00000010 1 0", r_busy, r_en0, r_a0);
        end
        run_req(6, 2'b10, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        tests_run++;
        if (r_res !== 32'h00000077 || r_cyc != 2) begin
            fails++; $display("FAIL b_addr6 got=%h cyc=%0d want 00000077 2", r_res, r_cyc);
        end
        run_req(2, 2'b01, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        tests_run++;
        if (r_res !== 32'h00003344 || r_cyc != 2) begin
            fails++; $display("FAIL h_addr2 got=%h cyc=%0d want 00003344 2", r_res, r_cyc);
        end
        run_req(4, 2'b11, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        tests_run++;
        if (r_res !== 32'h55667788 || r_a0 !== 10'd1) begin
            fails++; $display("FAIL sz11_addr4 got=%h a=%h want 55667788 1", r_res, r_a0);
        end
    endtask

    task automatic test_spanning();
        logic [31:0] want;
        run_req(3, 2'b00, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        want = Unal ? 32'h44556677 : 32'h44000000;
        tests_run++;
        if (r_res !== want || r_cyc != (Unal ? 3 : 2) || r_cnt != 1) begin
            fails++;
            $display("FAIL w_addr3 got=%h cyc=%0d cnt=%0d want %h", r_res, r_cyc, r_cnt, want);
        end
        tests_run++;
        if (r_busy !== (Unal ? 8'b0000_0110 : 8'b0000_0010)) begin
            fails++; $display("FAIL w_addr3_busy got=%b", r_busy);
        end
        tests_run++;
        if (r_a0 !== '0 || r_en1 !== Unal || (Unal && r_a1 !== 10'd1)) begin
            fails++;
            $display("FAIL w_addr3_bram a0=%h en1=%b a1=%h want 0 %b 1", r_a0, r_en1, r_a1, Unal);
        end
        run_req((1 << AW) - 1, 2'b01, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        want = Unal ? 32'h0000DD11 : 32'h0000DD00;
        tests_run++;
        if (r_res !== want || r_a0 !== 10'h3FF) begin
            fails++; $display("FAIL h_top got=%h a0=%h want %h 3ff", r_res, r_a0, want);
        end
        tests_run++;
        if (r_en1 !== Unal || r_a1 !== '0) begin
            fails++; $display("FAIL h_top_wrap en1=%b a1=%h want %b 0", r_en1, r_a1, Unal);
        end
    endtask

    task automatic test_ignore();
        logic [31:0] want;
        run_req(1, 2'b00, 1'b1, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        want = Unal ? 32'h22334455 : 32'h22334400;
        tests_run++;
        if (r_cnt != 1 || r_res !== want) begin
            fails++; $display("FAIL ignore_busy cnt=%0d got=%h want 1 %h", r_cnt, r_res, want);
        end
    endtask

    task automatic test_reset_mid();
        int vld_seen;
        @(negedge clk);
        rd_en = 1'b1; addr = AW'(3); sz = 2'b00;
        @(negedge clk);
        rd_en = 1'b0;
        if (Unal) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || resdata !== 32'h0 || resdata_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid busy=%b res=%h vld=%b want 0 0 0", busy, resdata, resdata_vld);
        end
        vld_seen = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (resdata_vld) vld_seen++;
        end
        tests_run++;
        if (vld_seen != 0) begin
            fails++; $display("FAIL reset_mid_novld got=%0d want 0", vld_seen);
        end
        run_req(0, 2'b10, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
        tests_run++;
        if (r_res !== 32'h00000011 || r_cnt != 1) begin
            fails++; $display("FAIL after_reset got=%h cnt=%0d want 00000011 1", r_res, r_cnt);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rd_en = 1'b1; addr = AW'(6); sz = 2'b10;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        rd_en = 1'b1; addr = AW'(2); sz = 2'b10;
        #1;
        tests_run++;
        if (resdata_vld !== 1'b1 || resdata !== 32'h77 || bram_rd_en !== 1'b1 ||
            bram_addr !== '0) begin
            fails++;
            $display("FAIL b2b_accept vld=%b res=%h en=%b a=%h want 1 77 1 0",
                     resdata_vld, resdata, bram_rd_en, bram_addr);
        end
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (resdata_vld !== 1'b1 || resdata !== 32'h33) begin
            fails++; $display("FAIL b2b_second vld=%b res=%h want 1 00000033", resdata_vld, resdata);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int a;
            logic [1:0] s;
            logic [31:0] want;
            int want_cyc;
            a = $urandom_range(0, (1 << AW) - 1);
            s = 2'($urandom_range(0, 3));
            want = model(a, s);
            want_cyc = (Unal && spans(a, s)) ? 3 : 2;
            run_req(a, s, 1'b0, r_res, r_cyc, r_cnt, r_busy, r_en0, r_a0, r_en1, r_a1);
            tests_run++;
            if (r_res !== want || r_cyc != want_cyc || r_cnt != 1) begin
                fails++;
                $display("FAIL random addr=%0d sz=%0d got=%h cyc=%0d cnt=%0d want %h %0d 1",
                         a, s, r_res, r_cyc, r_cnt, want, want_cyc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0]         = 32'h11223344;
        mem[1]         = 32'h55667788;
        mem[WORDS - 1] = 32'hAABBCCDD;
        rd_en = 1'b0; addr = '0; sz = 2'b00; rst_n = 1'b0;

        test_reset();
        test_aligned();
        test_spanning();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
